// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory and fills the IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect traps into a FAULT state until reset.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] instructionAddress,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    output logic [31:0] ifidInstruction,
    output logic [15:0] ifidPC,
    output logic        ifidValid,
    output logic [31:0] fetchCount,
    output logic        fetchFault
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [31:0] ifid_instr_q;
    logic [15:0] ifid_pc_q;
    logic        ifid_valid_q;
    logic [31:0] fetch_count_q;
    logic [15:0] pc_seq_d;
    logic [15:0] redirect_pc_d;
    logic        misaligned_d;

    // Sequential PC wraps modulo 2^16; redirect targets are word-aligned before use.
    always_comb begin
        pc_seq_d      = pc_q + 16'd4;
        redirect_pc_d = branchTarget & 16'hFFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_d  = (branchTarget[1:0] != 2'b00);
`else
        misaligned_d  = 1'b0;
`endif
    end

    // Fetch FSM: reset, then redirect over stall over sequential fetch; FAULT holds until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            ifid_instr_q  <= NOP_WORD;
            ifid_pc_q     <= RESET_PC;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (branchTaken) begin
                        ifid_valid_q <= 1'b0;
                        ifid_instr_q <= NOP_WORD;
                        if (misaligned_d) begin
                            state_q <= ST_FAULT;
                        end else begin
                            pc_q      <= redirect_pc_d;
                            ifid_pc_q <= redirect_pc_d;
                        end
                    end else if (!stall) begin
                        ifid_instr_q  <= instruction;
                        ifid_pc_q     <= pc_q;
                        ifid_valid_q  <= 1'b1;
                        pc_q          <= pc_seq_d;
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end else begin
                        pc_q <= pc_q;
                    end
                end
                ST_FAULT: begin
                    ifid_valid_q <= 1'b0;
                    ifid_instr_q <= NOP_WORD;
                end
                default: begin
                    state_q      <= ST_FAULT;
                    ifid_valid_q <= 1'b0;
                    ifid_instr_q <= NOP_WORD;
                end
            endcase
        end
    end

    assign instructionAddress = pc_q;
    assign ifidInstruction    = ifid_instr_q;
    assign ifidPC             = ifid_pc_q;
    assign ifidValid          = ifid_valid_q;
    assign fetchCount         = fetch_count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetchFault         = (state_q == ST_FAULT);
`else
    assign fetchFault         = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory model returns 0x1000_0000 + address.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [15:0] instructionAddress;
    logic [31:0] instruction;
    logic        stall;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic [31:0] ifidInstruction;
    logic [15:0] ifidPC;
    logic        ifidValid;
    logic [31:0] fetchCount;
    logic        fetchFault;

    int n_tests;
    int n_fail;

    localparam logic [31:0] NOP = 32'h00000013;

    instruction_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .instructionAddress(instructionAddress),
        .instruction       (instruction),
        .stall             (stall),
        .branchTaken       (branchTaken),
        .branchTarget      (branchTarget),
        .ifidInstruction   (ifidInstruction),
        .ifidPC            (ifidPC),
        .ifidValid         (ifidValid),
        .fetchCount        (fetchCount),
        .fetchFault        (fetchFault)
    );

    assign instruction = 32'h10000000 + {16'h0000, instructionAddress};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] pc, input logic [31:0] w,
                            input logic v, input logic [31:0] cnt);
        chk({tag, ".pc"},    {16'h0000, ifidPC}, {16'h0000, pc});
        chk({tag, ".instr"}, ifidInstruction, w);
        chk({tag, ".valid"}, {31'd0, ifidValid}, {31'd0, v});
        chk({tag, ".count"}, fetchCount, cnt);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 16'h0000;
        step();
        step();
        reset = 1'b0;
        chk_ifid("reset", 16'h0000, NOP, 1'b0, 32'd0);
        chk("reset.addr",  {16'h0, instructionAddress}, 32'h0000_0000);
        chk("reset.fault", {31'd0, fetchFault}, 32'd0);

        step();
        chk_ifid("f0", 16'h0000, 32'h10000000, 1'b1, 32'd1);
        chk("f0.addr", {16'h0, instructionAddress}, 32'h0000_0004);
        step();
        chk_ifid("f1", 16'h0004, 32'h10000004, 1'b1, 32'd2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 16'h0004, 32'h10000004, 1'b1, 32'd2);
            chk("stall.addr", {16'h0, instructionAddress}, 32'h0000_0008);
        end
        stall = 1'b0;
        step();
        chk_ifid("f2", 16'h0008, 32'h10000008, 1'b1, 32'd3);
        step();
        chk_ifid("f3", 16'h000C, 32'h1000000C, 1'b1, 32'd4);

        // Redirect beats a simultaneous stall.
        branchTaken  = 1'b1;
        branchTarget = 16'h0100;
        stall        = 1'b1;
        step();
        branchTaken = 1'b0;
        stall       = 1'b0;
        chk_ifid("br", 16'h0100, NOP, 1'b0, 32'd4);
        chk("br.addr", {16'h0, instructionAddress}, 32'h0000_0100);
        step();
        chk_ifid("br.tgt", 16'h0100, 32'h10000100, 1'b1, 32'd5);

        branchTaken  = 1'b1;
        branchTarget = 16'hFFF8;
        step();
        branchTaken = 1'b0;
        chk_ifid("wrap.bub", 16'hFFF8, NOP, 1'b0, 32'd5);
        step();
        chk_ifid("wrap0", 16'hFFF8, 32'h1000FFF8, 1'b1, 32'd6);
        step();
        chk_ifid("wrap1", 16'hFFFC, 32'h1000FFFC, 1'b1, 32'd7);
        chk("wrap.addr", {16'h0, instructionAddress}, 32'h0000_0000);
        step();
        chk_ifid("wrap2", 16'h0000, 32'h10000000, 1'b1, 32'd8);

        // Reset overrides redirect and stall.
        reset        = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 16'h0200;
        stall        = 1'b1;
        step();
        reset       = 1'b0;
        branchTaken = 1'b0;
        stall       = 1'b0;
        chk_ifid("midrst", 16'h0000, NOP, 1'b0, 32'd0);
        chk("midrst.addr", {16'h0, instructionAddress}, 32'h0000_0000);

        step();
        chk_ifid("f4", 16'h0000, 32'h10000000, 1'b1, 32'd1);

        branchTaken  = 1'b1;
        branchTarget = 16'h0102;
        step();
        branchTaken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis.fault", {31'd0, fetchFault}, 32'd1);
        chk("mis.addr",  {16'h0, instructionAddress}, 32'h0000_0004);
        chk("mis.valid", {31'd0, ifidValid}, 32'd0);
        branchTaken  = 1'b1;
        branchTarget = 16'h0200;
        step();
        branchTaken = 1'b0;
        chk("flt.addr",  {16'h0, instructionAddress}, 32'h0000_0004);
        chk("flt.fault", {31'd0, fetchFault}, 32'd1);
        chk("flt.instr", ifidInstruction, NOP);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rec.addr",  {16'h0, instructionAddress}, 32'h0000_0000);
        chk("rec.fault", {31'd0, fetchFault}, 32'd0);
`else
        chk_ifid("mis", 16'h0100, NOP, 1'b0, 32'd1);
        chk("mis.addr",  {16'h0, instructionAddress}, 32'h0000_0100);
        chk("mis.fault", {31'd0, fetchFault}, 32'd0);
        step();
        chk_ifid("mis.tgt", 16'h0100, 32'h10000100, 1'b1, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
